aclk_alarm_writer: RTL and testbench

//  Keypad-side writer for the alarm time register. Collects up to four decimal
//  key digits (HH:MM), validates them as a 24-hour time, and on the ALARM key

---
 rtl/aclk_alarm_writer.sv | 150 +++++++++++++++
 tb/tb_aclk_alarm_writer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aclk_alarm_writer.sv
// Keypad-side writer for the alarm register: collects HH:MM digits, validates as 24-hour time, strobes load_new_a on ALARM.
// Latency: ALARM at edge N -> load_new_a high after edge N+2; keys dropped while busy. Optional idle abort: ACLK_ENTRY_TIMEOUT_EN.
module aclk_alarm_writer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_a,
    output logic       busy,
    output logic       entry_err,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOAD} state_t;

    localparam logic [3:0] KEY_ALARM  = 4'hA;
    localparam logic [3:0] KEY_CANCEL = 4'hC;
    localparam int         TMR_W      = $clog2(TIMEOUT_CYCLES + 1);

    state_t     state;
    logic [2:0] count;
    logic       is_digit;
    logic       time_ok;

    assign is_digit = (key_code <= 4'd9);

    assign time_ok = (new_alarm_ms_hr <= 4'd2)
                  && !((new_alarm_ms_hr == 4'd2) && (new_alarm_ls_hr > 4'd3))
                  && (new_alarm_ms_min <= 4'd5)
                  && (new_alarm_ls_min <= 4'd9);

`ifdef ACLK_ENTRY_TIMEOUT_EN
    logic [TMR_W-1:0] timer;
`else
    logic [TMR_W-1:0] unused_cfg;
    assign unused_cfg = TMR_W'(TIMEOUT_CYCLES);
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= 3'd0;
            new_alarm_ms_hr  <= 4'h0;
            new_alarm_ls_hr  <= 4'h0;
            new_alarm_ms_min <= 4'h0;
            new_alarm_ls_min <= 4'h0;
            load_new_a       <= 1'b0;
            busy             <= 1'b0;
            entry_err        <= 1'b0;
`ifdef ACLK_ENTRY_TIMEOUT_EN
            timer            <= '0;
            timeout          <= 1'b0;
`endif
        end else begin
            load_new_a <= 1'b0;
            entry_err  <= 1'b0;
`ifdef ACLK_ENTRY_TIMEOUT_EN
            timeout    <= 1'b0;
            timer      <= '0;
`endif
            case (state)
                IDLE: begin
                    if (key_valid && is_digit) begin
                        new_alarm_ms_hr  <= 4'h0;
                        new_alarm_ls_hr  <= 4'h0;
                        new_alarm_ms_min <= 4'h0;
                        new_alarm_ls_min <= key_code;
                        count            <= 3'd1;
                        state            <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            // Shift left so the display fills from the right like a calculator.
                            new_alarm_ms_hr  <= new_alarm_ls_hr;
                            new_alarm_ls_hr  <= new_alarm_ms_min;
                            new_alarm_ms_min <= new_alarm_ls_min;
                            new_alarm_ls_min <= key_code;
                            if (count != 3'd4)
                                count <= count + 3'd1;
                        end else if (key_code == KEY_ALARM) begin
                            if (count == 3'd4) begin
                                state <= CHECK;
                                busy  <= 1'b1;
                            end else begin
                                entry_err        <= 1'b1;
                                new_alarm_ms_hr  <= 4'h0;
                                new_alarm_ls_hr  <= 4'h0;
                                new_alarm_ms_min <= 4'h0;
                                new_alarm_ls_min <= 4'h0;
                                count            <= 3'd0;
                                state            <= IDLE;
                            end
                        end else if (key_code == KEY_CANCEL) begin
                            new_alarm_ms_hr  <= 4'h0;
                            new_alarm_ls_hr  <= 4'h0;
                            new_alarm_ms_min <= 4'h0;
                            new_alarm_ls_min <= 4'h0;
                            count            <= 3'd0;
                            state            <= IDLE;
                        end
`ifdef ACLK_ENTRY_TIMEOUT_EN
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout          <= 1'b1;
                        new_alarm_ms_hr  <= 4'h0;
                        new_alarm_ls_hr  <= 4'h0;
                        new_alarm_ms_min <= 4'h0;
                        new_alarm_ls_min <= 4'h0;
                        count            <= 3'd0;
                        state            <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
`endif
                    end
                end
                CHECK: begin
                    if (time_ok) begin
                        state <= LOAD;
                    end else begin
                        entry_err        <= 1'b1;
                        busy             <= 1'b0;
                        new_alarm_ms_hr  <= 4'h0;
                        new_alarm_ls_hr  <= 4'h0;
                        new_alarm_ms_min <= 4'h0;
                        new_alarm_ls_min <= 4'h0;
                        count            <= 3'd0;
                        state            <= IDLE;
                    end
                end
                LOAD: begin
                    // Buffer is left intact so the display keeps showing the committed alarm.
                    load_new_a <= 1'b1;
                    busy       <= 1'b0;
                    count      <= 3'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_alarm_writer.sv
// Scoreboard bench for aclk_alarm_writer: expected strobes queued at stimulus time, matched as the DUT emits them.
module tb_aclk_alarm_writer;

    localparam logic [1:0] EV_LOAD = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;
    localparam logic [1:0] EV_TMO  = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] dat;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
    logic       load_new_a, busy, entry_err, timeout;
    logic [15:0] bufv;

    int n_checks = 0;
    int n_fail = 0;
    ev_t exp_q[$];

    aclk_alarm_writer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .key_valid(key_valid),
        .key_code(key_code),
        .new_alarm_ms_hr(new_alarm_ms_hr),
        .new_alarm_ls_hr(new_alarm_ls_hr),
        .new_alarm_ms_min(new_alarm_ms_min),
        .new_alarm_ls_min(new_alarm_ls_min),
        .load_new_a(load_new_a),
        .busy(busy),
        .entry_err(entry_err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign bufv = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};

    // Monitor: pops the scoreboard whenever a strobe appears and checks strobe exclusivity.
    logic prev_load = 1'b0;
    always @(negedge clk) begin : monitor
        ev_t        e;
        logic [1:0] k;
        if (!reset) begin
            if (load_new_a || entry_err || timeout) begin
                k = load_new_a ? EV_LOAD : (entry_err ? EV_ERR : EV_TMO);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got kind %0d buf %h, expected no event", k, bufv);
                end else begin
                    e = exp_q.pop_front();
                    if (k !== e.kind || bufv !== e.dat) begin
                        n_fail++;
                        $display("FAIL event_match: got kind %0d buf %h, expected kind %0d buf %h",
                                 k, bufv, e.kind, e.dat);
                    end
                end
            end
            if (load_new_a) begin
                n_checks++;
                if (entry_err !== 1'b0 || prev_load !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_exclusive: entry_err %b prev_load %b, expected 0 0", entry_err, prev_load);
                end
            end
        end
        prev_load = load_new_a;
    end

    task automatic press(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic press_word(input logic [15:0] w);
        for (int i = 3; i >= 0; i--) press(w[i*4 +: 4]);
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd5;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bufv !== 16'h0000) begin
            n_fail++; $display("FAIL reset_buf: got %h, expected 0000", bufv);
        end
        n_checks++;
        if ({load_new_a, busy, entry_err, timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, expected 0000", {load_new_a, busy, entry_err, timeout});
        end
        key_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_latency;
        exp_q.push_back('{EV_LOAD, 16'h1230});
        press_word(16'h1230);
        n_checks++;
        if (bufv !== 16'h1230) begin
            n_fail++; $display("FAIL entry_shift: got %h, expected 1230", bufv);
        end
        press(4'hA);
        n_checks++;
        if ({busy, load_new_a} !== 2'b10) begin
            n_fail++; $display("FAIL lat_check_cycle: busy,load got %b, expected 10", {busy, load_new_a});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, load_new_a} !== 2'b10) begin
            n_fail++; $display("FAIL lat_load_state: busy,load got %b, expected 10", {busy, load_new_a});
        end
        @(negedge clk);
        n_checks++;
        if ({busy, load_new_a} !== 2'b01) begin
            n_fail++; $display("FAIL lat_strobe: busy,load got %b, expected 01", {busy, load_new_a});
        end
        @(negedge clk);
        n_checks++;
        if (load_new_a !== 1'b0 || bufv !== 16'h1230) begin
            n_fail++; $display("FAIL lat_after: load %b buf %h, expected 0 1230", load_new_a, bufv);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL load_missing: %0d events pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_validation;
        logic [15:0] words[6] = '{16'h2400, 16'h0960, 16'h3000, 16'h2359, 16'h0000, 16'h1959};
        logic        ok[6]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            if (ok[i]) exp_q.push_back('{EV_LOAD, words[i]});
            else       exp_q.push_back('{EV_ERR, 16'h0000});
            press_word(words[i]);
            press(4'hA);
            repeat (4) @(negedge clk);
            n_checks++;
            if (exp_q.size() !== 0) begin
                n_fail++; $display("FAIL validate_%h: %0d events pending, expected 0", words[i], exp_q.size());
            end
            n_checks++;
            if (bufv !== (ok[i] ? words[i] : 16'h0000)) begin
                n_fail++; $display("FAIL validate_buf_%h: got %h", words[i], bufv);
            end
        end
    endtask

    task automatic test_short_and_fifth;
        exp_q.push_back('{EV_ERR, 16'h0000});
        press(4'd1); press(4'd2); press(4'hA);
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0 || bufv !== 16'h0000) begin
            n_fail++; $display("FAIL short_entry: pending %0d buf %h, expected 0 0000", exp_q.size(), bufv);
        end
        exp_q.push_back('{EV_LOAD, 16'h1230});
        press(4'd9); press_word(16'h1230); press(4'hA);
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL fifth_digit: %0d events pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_cancel_and_ignored;
        press(4'd1); press(4'd2); press(4'hC);
        n_checks++;
        if (bufv !== 16'h0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel_clear: buf %h busy %b, expected 0000 0", bufv, busy);
        end
        press(4'hA); press(4'hB); press(4'hF);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bufv !== 16'h0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignore: buf %h busy %b, expected 0000 0", bufv, busy);
        end
    endtask

    task automatic test_busy_drop;
        exp_q.push_back('{EV_LOAD, 16'h0845});
        press_word(16'h0845);
        press(4'hA);
        press(4'd5);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_high: got %b, expected 1", busy);
        end
        press(4'd7);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bufv !== 16'h0845 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL busy_drop: buf %h pending %0d, expected 0845 0", bufv, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        press(4'd1); press(4'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (bufv !== 16'h0000 || {load_new_a, busy, entry_err} !== 3'b000) begin
            n_fail++; $display("FAIL reset_mid: buf %h flags %b, expected 0000 000", bufv, {load_new_a, busy, entry_err});
        end
        press(4'hA);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bufv !== 16'h0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_then_alarm: buf %h busy %b, expected 0000 0", bufv, busy);
        end
    endtask

    task automatic test_timeout;
`ifdef ACLK_ENTRY_TIMEOUT_EN
        exp_q.push_back('{EV_TMO, 16'h0000});
        press(4'd1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0 || bufv !== 16'h0000) begin
            n_fail++; $display("FAIL timeout_fire: pending %0d buf %h, expected 0 0000", exp_q.size(), bufv);
        end
        press(4'd1);
        repeat (7) @(negedge clk);
        press(4'd2);
        n_checks++;
        if (bufv !== 16'h0012) begin
            n_fail++; $display("FAIL timeout_key_rescue: buf %h, expected 0012", bufv);
        end
        press(4'hC);
        repeat (2) @(negedge clk);
`else
        press(4'd1);
        repeat (40) @(negedge clk);
        n_checks++;
        if (bufv !== 16'h0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL no_timeout: buf %h timeout %b, expected 0001 0", bufv, timeout);
        end
        press(4'hC);
`endif
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_validation();
        test_short_and_fifth();
        test_cancel_and_ignored();
        test_busy_drop();
        test_reset_mid();
        test_timeout();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL final_queue: %0d events pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
